// File: rtl/sig_cond_pkg.sv
// Shared types and defaults for the sig_cond measurement front end.
package sig_cond_pkg;

    localparam int DEF_N_CH        = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 3;
    localparam int DEF_CNT_W       = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } gate_state_t;

    // Channel-select width; never narrower than one bit.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/sig_cond_ch.sv
// One input channel: synchroniser chain, level-acceptance filter, rising-edge pulse.
module sig_cond_ch
    import sig_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic lvl_o,
    output logic rise_o
);

    localparam int              FC_W    = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FC_W-1:0]        fcnt_q, fcnt_d;
    logic                   lvl_q, lvl_d;
    logic                   lvl_prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        fcnt_d = '0;
        lvl_d  = lvl_q;
        if (s != lvl_q) begin
            if (fcnt_q == FC_LAST) begin
                lvl_d = ~lvl_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            fcnt_q     <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_i};
            fcnt_q     <= fcnt_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/sig_cond_gate.sv
// N-channel conditioning front end: filtered levels, edge pulses, XOR phase output
// and a gate FSM that opens/closes the counter enable on reference-channel edges.
//
// state   | meaning
// IDLE    | no window, waiting for o_en
// ARM     | o_en seen, waiting for first reference edge
// OPEN    | window running, counting reference periods
// CLOSING | o_en dropped, window ends on next reference edge
module sig_cond_gate
    import sig_cond_pkg::*;
#(
    parameter  int N_CH        = DEF_N_CH,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter  int FILT_LEN    = DEF_FILT_LEN,
    parameter  int CNT_W       = DEF_CNT_W,
    localparam int SEL_W       = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  sig_in,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    input  logic             o_en,
    output logic [N_CH-1:0]  ch_out,
    output logic [N_CH-1:0]  rise,
    output logic             q,
    output logic             cnt_en,
    output logic             gate_done,
    output logic [CNT_W-1:0] n_ref
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  lvl;
    logic [N_CH-1:0]  rise_w;
    logic             q_q;
    gate_state_t      state_q, state_d;
    logic [SEL_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] n_ref_q, n_ref_d;
    logic             done_q, done_d;
    logic             win_close;
    logic             ref_rise;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sig_cond_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .sig_i (sig_in[i]),
            .lvl_o (lvl[i]),
            .rise_o(rise_w[i])
        );
    end

    // Out-of-range selects fall back to channel 0.
    function automatic logic [SEL_W-1:0] map_sel(input logic [SEL_W-1:0] s);
        return (int'(s) < N_CH) ? s : '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign ref_rise = rise_w[ref_q];

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        pcnt_d    = pcnt_q;
        n_ref_d   = n_ref_q;
        done_d    = 1'b0;
        win_close = 1'b0;
        case (state_q)
            IDLE: begin
                if (o_en) begin
                    state_d = ARM;
                    ref_d   = map_sel(sel_a);
                end
            end
            ARM: begin
                if (!o_en) begin
                    state_d = IDLE;
                end else if (ref_rise) begin
                    state_d = OPEN;
                    pcnt_d  = '0;
                end
            end
            OPEN: begin
                if (ref_rise && !o_en) begin
                    win_close = 1'b1;
                end else if (ref_rise) begin
                    pcnt_d = sat_inc(pcnt_q);
                end else if (!o_en) begin
                    state_d = CLOSING;
                end
            end
            CLOSING: begin
                if (ref_rise) begin
                    win_close = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The closing edge completes the last period, hence the +1.
        if (win_close) begin
            n_ref_d = sat_inc(pcnt_q);
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ref_q   <= '0;
            pcnt_q  <= '0;
            n_ref_q <= '0;
            done_q  <= 1'b0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            pcnt_q  <= pcnt_d;
            n_ref_q <= n_ref_d;
            done_q  <= done_d;
            q_q     <= lvl[map_sel(sel_a)] ^ lvl[map_sel(sel_b)];
        end
    end

    assign ch_out    = lvl;
    assign rise      = rise_w;
    assign q         = q_q;
    assign cnt_en    = (state_q == OPEN) || (state_q == CLOSING);
    assign gate_done = done_q;
    assign n_ref     = n_ref_q;

endmodule

// File: doc/sig_cond_gate.md
Name: sig_cond_gate

Overview:
Parametrised N-channel front end for the frequency/phase measurement path. It replaces the fixed two-input register-and-XOR stage with:
- per-channel synchronisers and glitch filters;
- rising-edge pulses per channel;
- a runtime-selectable XOR phase output;
- a gate FSM that aligns the counter enable to edges of a reference channel and counts whole reference periods.

It sits between the external comparator inputs and the period/phase counters.

Parameters:
N_CH, 2, number of input channels (2..16)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 3, consecutive equal synchronised samples required to accept a new level (>=1; 1 = no filtering)
CNT_W, 24, width of the reference-period counter
SEL_W, derived as max(1, clog2(N_CH)); localparam, not overridable

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
sig_in  in  N_CH  raw asynchronous channel inputs
sel_a  in  SEL_W  XOR operand A and gate reference channel
sel_b  in  SEL_W  XOR operand B
o_en  in  1  gate request, synchronous to clk
ch_out  out  N_CH  filtered channel levels
rise  out  N_CH  one-cycle rising-edge pulse per channel
q  out  1  XOR of selected channels
cnt_en  out  1  edge-aligned counter enable
gate_done  out  1  one-cycle pulse when a window closes
n_ref  out  CNT_W  reference periods in the last completed window

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low. While rst_n=0, all flops clear: sync chains, filter counters, ch_out, rise, q, cnt_en, gate_done, n_ref=0, FSM in IDLE. Deassertion mid-window drops to IDLE with no gate_done.
- Synchroniser: SYNC_STAGES-flop chain per channel; s[i] is the last stage.
- Filter:
  - fcnt[i] clears when s[i]==ch_out[i].
  - When s[i]!=ch_out[i] and fcnt[i]==FILT_LEN-1, ch_out[i] toggles and fcnt[i] clears; otherwise fcnt[i] increments.
  - Latency: ch_out changes on the (SYNC_STAGES+FILT_LEN)th rising edge counting the first edge that samples the new level.
  - Pulses shorter than FILT_LEN cycles after synchronisation never reach ch_out.
- Edges: rise[i] = ch_out[i] & ~ch_out_d[i]. It is high exactly in the first cycle ch_out[i] is high; no fall pulses.
- XOR:
  - q registered, equals ch_out[sel_a]^ch_out[sel_b] of the previous cycle; 1 cycle after ch_out.
  - sel_a==sel_b gives q=0.
  - A sel index >= N_CH selects channel 0.
  - sel changes take effect on the next edge.
- Gate FSM (states IDLE, ARM, OPEN, CLOSING; ref = channel latched from sel_a on leaving IDLE; sel_a changes during a window are ignored):
  - IDLE: cnt_en=0. o_en=1 -> ARM, latch ref.
  - ARM: o_en=0 -> IDLE; this aborts, no done pulse, n_ref unchanged. rise[ref] -> OPEN; cnt_en=1 from the next cycle; period count pcnt clears to 0.
  - OPEN: cnt_en=1; each rise[ref] increments pcnt. o_en=0 -> CLOSING. If o_en=0 and rise[ref] occur in the same cycle, the window closes immediately: that edge is counted and treated as the closing edge.
  - CLOSING: cnt_en=1. On rise[ref] the window closes.
- Window close (common to both paths above):
  - pcnt+1 is loaded into n_ref.
  - gate_done pulses for 1 cycle.
  - cnt_en is 0 from the next cycle.
  - FSM returns to IDLE.
  - Window = exactly n_ref whole reference periods.
- Saturation: pcnt saturates at all-ones and never wraps. n_ref = all-ones flags overflow.
- o_en held high after a close re-arms from IDLE on the next cycle.
- Back-to-back windows are separated by at least one reference edge.

Decomposition:
- Package sig_cond_pkg:
  - gate_state_t enum {IDLE, ARM, OPEN, CLOSING};
  - sel-width helper function;
  - default parameter constants.
- Sub-module sig_cond_ch (sync chain + filter + edge detect, one channel) is instantiated N_CH times in a generate loop.
- XOR, select mux, gate FSM and counter stay in the top.

Test Plan:
- Latency, defaults: hold sig_in[0] low, drive it high before edge 1 -> ch_out[0] rises after edge 5; rise[0] is high for exactly that one cycle; q (sel_a=0, sel_b=1, ch1 low) rises after edge 6.
- Glitch rejection, FILT_LEN=3: 2-cycle high pulse on sig_in[1] -> ch_out[1], rise[1] and q stay 0. A 3-cycle pulse -> ch_out[1] high for 3 cycles.
- Phase XOR: ch0 and ch1 square waves, period 20 cycles, ch1 lagging 5 -> q high 10 of every 20 cycles. sel_a=sel_b=1 -> q=0.
- Gate alignment: ref period 10 cycles, o_en high for 35 cycles -> cnt_en rises the cycle after a ref rise and falls the cycle after a ref rise; n_ref=4; one gate_done pulse.
- Abort and reset: o_en pulsed high for 3 cycles with no ref edge -> FSM back to IDLE, no gate_done, n_ref unchanged. rst_n low mid-OPEN -> cnt_en=0 immediately and all outputs 0.
- Saturation: CNT_W=4, window of 20 ref periods -> n_ref=15.
